// File: rtl/alu_issue_ctrl.sv
// Issue controller sitting between an instruction source and a fixed-latency 4-bit ALU.
// Accepts one instruction at a time, optionally forwards the last result as operand A.
module alu_issue_ctrl #(
   parameter int ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [11:0] instr,
   input  logic        instr_fwd,
   output logic        instr_ready,
   output logic        alu_en,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic [3:0]  alu_fun,
   input  logic [3:0]  alu_out,
   input  logic        alu_carry,
   output logic        res_valid,
   output logic [3:0]  res_data,
   output logic        res_carry,
   input  logic        res_ready,
   output logic        illegal,
   output logic [7:0]  op_count,
   output logic [7:0]  err_count
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

   localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

   state_t     state;
   state_t     state_nxt;
   logic       up;
   logic       accept;
   logic       drive_ops;
   logic       capture;
   logic [3:0] fun_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic       fwd_q;
   logic [3:0] last_res;
   logic [2:0] wait_cnt;

   function automatic logic is_legal(input logic [3:0] f);
      return (f <= 4'd5) || (f == 4'd8) || (f == 4'd9);
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // up holds instr_ready low until the first edge after reset release.
   always_comb begin
      state_nxt   = state;
      instr_ready = 1'b0;
      accept      = 1'b0;
      alu_en      = 1'b0;
      drive_ops   = 1'b0;
      capture     = 1'b0;
      res_valid   = 1'b0;
      illegal     = 1'b0;
      case (state)
         IDLE: begin
            instr_ready = up;
            if (up && instr_valid) begin
               accept    = 1'b1;
               state_nxt = is_legal(instr[11:8]) ? ISSUE : ERR;
            end
         end
         ISSUE: begin
            alu_en    = 1'b1;
            drive_ops = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            drive_ops = 1'b1;
            if (wait_cnt == 3'd0) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = IDLE;
         end
         ERR: begin
            illegal   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign alu_a   = drive_ops ? (fwd_q ? last_res : a_q) : 4'd0;
   assign alu_b   = drive_ops ? b_q   : 4'd0;
   assign alu_fun = drive_ops ? fun_q : 4'd0;

   // The counter is loaded with ALU_LAT in ISSUE and the capture happens on the
   // edge where it has reached zero, i.e. ALU_LAT+1 edges after the alu_en cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         up        <= 1'b0;
         fun_q     <= 4'd0;
         a_q       <= 4'd0;
         b_q       <= 4'd0;
         fwd_q     <= 1'b0;
         wait_cnt  <= 3'd0;
         last_res  <= 4'd0;
         res_data  <= 4'd0;
         res_carry <= 1'b0;
         op_count  <= 8'd0;
         err_count <= 8'd0;
      end else begin
         up <= 1'b1;
         if (accept) begin
            fun_q <= instr[11:8];
            a_q   <= instr[7:4];
            b_q   <= instr[3:0];
            fwd_q <= instr_fwd;
            if (!is_legal(instr[11:8])) err_count <= sat_inc(err_count);
         end
         if (state == ISSUE) begin
            wait_cnt <= LAT_LOAD;
         end else if (state == WAIT && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
         end
         if (capture) begin
            res_data  <= alu_out;
            res_carry <= alu_carry;
            last_res  <= alu_out;
            op_count  <= sat_inc(op_count);
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed stimulus pushes expected ALU
// requests and results; a negedge monitor pops and compares them.
module tb_alu_issue_ctrl;

   localparam int LAT = 1;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic [11:0] instr;
   logic        instr_fwd;
   logic        instr_ready;
   logic        alu_en;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [3:0]  alu_fun;
   logic [3:0]  alu_out;
   logic        alu_carry;
   logic        res_valid;
   logic [3:0]  res_data;
   logic        res_carry;
   logic        res_ready;
   logic        illegal;
   logic [7:0]  op_count;
   logic [7:0]  err_count;

   alu_issue_ctrl #(.ALU_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_fwd(instr_fwd), .instr_ready(instr_ready), .alu_en(alu_en),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(alu_out),
      .alu_carry(alu_carry), .res_valid(res_valid), .res_data(res_data),
      .res_carry(res_carry), .res_ready(res_ready), .illegal(illegal),
      .op_count(op_count), .err_count(err_count)
   );

   // Behavioural ALU: operands are held stable for the whole operation.
   always_comb begin
      logic [4:0] r;
      r = 5'd0;
      case (alu_fun)
         4'd0: r = {1'b0, alu_a & alu_b};
         4'd1: r = {1'b0, alu_a | alu_b};
         4'd2: r = {1'b0, alu_a ^ alu_b};
         4'd3: r = {1'b0, ~alu_a};
         4'd4: r = {1'b0, alu_a};
         4'd5: r = {1'b0, alu_b};
         4'd8: r = {1'b0, alu_a} + {1'b0, alu_b};
         4'd9: r = {1'b0, alu_a} - {1'b0, alu_b};
         default: r = 5'd0;
      endcase
      {alu_carry, alu_out} = r;
   end

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] fun;
      int         acc;
   } alu_exp_t;

   typedef struct {
      logic [3:0] data;
      logic       carry;
      int         acc;
   } res_exp_t;

   alu_exp_t exp_alu[$];
   res_exp_t exp_res[$];
   int       exp_ill[$];

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int alu_en_cnt = 0;
   int rv_cnt  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      errors++;
      $display("FAIL %s: timed out, got no response, required one", name);
   endtask

   // Monitor: pops expectations whenever the DUT presents an ALU request,
   // a new result, or an illegal pulse.
   initial begin
      alu_exp_t cur;
      res_exp_t er;
      logic     busy;
      logic     rv_prev;
      int       ia;
      busy    = 1'b0;
      rv_prev = 1'b0;
      cur     = '{a: 4'd0, b: 4'd0, fun: 4'd0, acc: 0};
      forever begin
         @(negedge clk);
         if (!rst) begin
            busy    = 1'b0;
            rv_prev = 1'b0;
         end else begin
            if (res_valid && !rv_prev) begin
               rv_cnt++;
               busy = 1'b0;
               if (exp_res.size() == 0) begin
                  check("unexpected res_valid", 1, 0);
               end else begin
                  er = exp_res.pop_front();
                  check("res_data", res_data, er.data);
                  check("res_carry", res_carry, er.carry);
                  check("res latency", cyc - er.acc, 2 + LAT);
               end
            end
            rv_prev = res_valid;
            if (alu_en) begin
               alu_en_cnt++;
               if (exp_alu.size() == 0) begin
                  check("unexpected alu_en", 1, 0);
               end else begin
                  cur  = exp_alu.pop_front();
                  busy = 1'b1;
                  check("alu operands", {alu_a, alu_b, alu_fun}, {cur.a, cur.b, cur.fun});
                  check("alu_en latency", cyc - cur.acc, 0);
               end
            end else if (busy) begin
               check("alu operands held", {alu_a, alu_b, alu_fun}, {cur.a, cur.b, cur.fun});
            end
            if (illegal) begin
               if (exp_ill.size() == 0) begin
                  check("unexpected illegal", 1, 0);
               end else begin
                  ia = exp_ill.pop_front();
                  check("illegal latency", cyc - ia, 0);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) fail_now("wait instr_ready");
   endtask

   task automatic accept_instr(input logic [11:0] ins, input logic fwd);
      wait_ready();
      instr       = ins;
      instr_fwd   = fwd;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      instr_fwd   = 1'b0;
   endtask

   task automatic send_legal(input logic [11:0] ins, input logic fwd, input logic [3:0] ea,
                             input logic [3:0] ed, input logic ec);
      accept_instr(ins, fwd);
      exp_alu.push_back('{a: ea, b: ins[3:0], fun: ins[11:8], acc: cyc});
      exp_res.push_back('{data: ed, carry: ec, acc: cyc});
   endtask

   task automatic send_illegal(input logic [11:0] ins);
      accept_instr(ins, 1'b0);
      exp_ill.push_back(cyc);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_res.size() != 0 || exp_ill.size() != 0 || !instr_ready) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) fail_now("wait operation done");
   endtask

   initial begin
      int snap;
      int n;
      rst = 1'b0;
      instr_valid = 1'b0;
      instr = 12'd0;
      instr_fwd = 1'b0;
      res_ready = 1'b1;

      // Reset with random inputs
      for (int i = 0; i < 2; i++) begin
         instr_valid = 1'($urandom);
         instr       = 12'($urandom);
         instr_fwd   = 1'($urandom);
         res_ready   = 1'($urandom);
         @(negedge clk);
         check("reset outputs",
               {instr_ready, alu_en, res_valid, illegal, res_carry, res_data, alu_a, alu_b, alu_fun},
               32'd0);
         check("reset counters", {op_count, err_count}, 32'd0);
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      instr_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      check("ready before first edge", instr_ready, 0);
      tick();
      check("ready after first edge", instr_ready, 1);

      // Basic add 2+4
      send_legal(12'b1000_0010_0100, 1'b0, 4'd2, 4'd6, 1'b0);
      wait_done();
      check("op_count after add", op_count, 1);

      // Illegal opcode 1010
      snap = alu_en_cnt;
      send_illegal(12'b1010_0001_0001);
      wait_done();
      check("err_count after illegal", err_count, 1);
      check("op_count after illegal", op_count, 1);
      check("alu_en on illegal", alu_en_cnt, snap);

      // Forwarding of the previous 0110 result
      send_legal(12'b1000_1111_0011, 1'b1, 4'd6, 4'd9, 1'b0);
      send_legal(12'b1001_0011_0101, 1'b0, 4'd3, 4'hE, 1'b1);
      send_legal(12'b1000_1111_0001, 1'b0, 4'hF, 4'h0, 1'b1);
      send_legal(12'b0000_1100_1010, 1'b0, 4'hC, 4'h8, 1'b0);
      send_legal(12'b0010_1100_1010, 1'b0, 4'hC, 4'h6, 1'b0);
      send_legal(12'b0011_0101_0000, 1'b0, 4'h5, 4'hA, 1'b0);
      send_legal(12'b0101_0000_0111, 1'b0, 4'h0, 4'h7, 1'b0);
      send_illegal(12'b0110_0000_0000);
      send_illegal(12'b0111_0000_0000);
      send_illegal(12'b1111_0000_0000);
      wait_done();
      check("op_count after mix", op_count, 8);
      check("err_count after mix", err_count, 4);

      // Backpressure, with an instruction offered that must be ignored
      res_ready = 1'b0;
      send_legal(12'b1000_0001_0001, 1'b0, 4'd1, 4'd2, 1'b0);
      n = 0;
      while (!res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) fail_now("wait res_valid");
      instr = 12'hF00;
      instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("held res_valid", res_valid, 1);
         check("held result", {res_carry, res_data}, {1'b0, 4'd2});
         check("held instr_ready", instr_ready, 0);
      end
      res_ready = 1'b1;
      instr_valid = 1'b0;
      tick();
      check("res_valid after release", res_valid, 0);
      check("ready after release", instr_ready, 1);
      check("result kept in idle", {res_carry, res_data}, {1'b0, 4'd2});
      check("counters after backpressure", {op_count, err_count}, {8'd9, 8'd4});

      // Reset during WAIT abandons the operation
      accept_instr(12'b1000_0111_0111, 1'b0);
      exp_alu.push_back('{a: 4'd7, b: 4'd7, fun: 4'd8, acc: cyc});
      tick();
      rst = 1'b0;
      snap = rv_cnt;
      @(negedge clk);
      check("mid-op reset outputs",
            {instr_ready, alu_en, res_valid, illegal, res_carry, res_data, alu_a, alu_b, alu_fun},
            32'd0);
      check("mid-op reset counters", {op_count, err_count}, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("res_valid after abort", rv_cnt, snap);
      check("op_count after abort", op_count, 0);
      check("alu request consumed", exp_alu.size(), 0);

      // Forwarding from the cleared last-result register
      send_legal(12'b1000_0101_0010, 1'b1, 4'd0, 4'd2, 1'b0);
      wait_done();
      check("op_count after fwd zero", op_count, 1);

      // Saturation of both counters
      for (int i = 0; i < 260; i++) begin
         send_legal({4'b0100, 4'(i), 4'h0}, 1'b0, 4'(i), 4'(i), 1'b0);
      end
      wait_done();
      check("op_count saturated", op_count, 255);
      for (int i = 0; i < 260; i++) send_illegal(12'hB00);
      wait_done();
      check("err_count saturated", err_count, 255);
      check("op_count still saturated", op_count, 255);

      tick();
      check("pending expectations", exp_alu.size() + exp_res.size() + exp_ill.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
